multicycle_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 4-bit-opcode CPU. It walks each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK using the same opcode categories as the control unit (ALU / MEMORY / CONTROL / SYSTEM). It drives the strobes that load the instruction register, update the PC, access data memory and write the register file. It sits between the instruction/data memory handshakes and the datapath.

---
 rtl/multicycle_sequencer.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//
// Multi-cycle control sequencer for the 4-bit-opcode CPU. Each instruction
// walks FETCH -> DECODE -> EXECUTE -> (MEMORY) -> (WRITEBACK). The sequencer
// drives the IR load, PC update, data-memory and register-file strobes.
//
// Optional feature: define SEQ_MEM_TIMEOUT_EN to build a data-memory wait
// watchdog. After TIMEOUT_CYCLES consecutive waiting cycles in MEMORY, the
// sequencer halts and raises `fault`. Without the macro, MEMORY waits forever
// and `fault` is tied low.

module multicycle_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    // Execution class of an opcode. Loads and stores share the MEMORY
    // category but are split here because they leave MEMORY differently.
    typedef enum logic [2:0] {
        K_ALU,
        K_LOAD,
        K_STORE,
        K_BEQ,
        K_JAL,
        K_HALT,
        K_NOP
    } kind_t;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_ADDI  = 4'b0010;
    localparam logic [3:0] OP_LOAD  = 4'b0011;
    localparam logic [3:0] OP_STORE = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b0110;
    localparam logic [3:0] OP_JAL   = 4'b0111;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Reject configurations that cannot work at elaboration time.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("multicycle_sequencer: TIMEOUT_CYCLES must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("multicycle_sequencer: CNT_W must be at least 1");
    end

    // Map an opcode onto its execution class. Opcode 1000 (NOP) and every
    // unassigned opcode fall into the NOP class.
    function automatic kind_t classify(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI: classify = K_ALU;
            OP_LOAD:                 classify = K_LOAD;
            OP_STORE:                classify = K_STORE;
            OP_BEQ:                  classify = K_BEQ;
            OP_JAL:                  classify = K_JAL;
            OP_HALT:                 classify = K_HALT;
            default:                 classify = K_NOP;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [3:0]       op_q;
    kind_t            kind;
    logic [CNT_W-1:0] count_q;
    logic             mem_timeout;

    assign kind = classify(op_q);

    // State register. Reset returns the sequencer to FETCH.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking (<=) so every flop samples
        // the values from before the edge, independent of statement order.
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode register: captured once per instruction, in DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
        end else if (state_q == S_DECODE) begin
            op_q <= opcode;
        end
    end

    // Retired-instruction counter. It wraps naturally modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign instr_count = count_q;

    // ------------------------------------------------------------------
    // Optional data-memory watchdog
    // ------------------------------------------------------------------
`ifdef SEQ_MEM_TIMEOUT_EN
    // The counter only needs to reach TIMEOUT_CYCLES-1. On the waiting cycle
    // that sees that value, the sequencer leaves MEMORY.
    localparam int unsigned WAIT_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WAIT_W-1:0] wait_cnt;
    logic              fault_q;

    assign mem_timeout = (state_q == S_MEMORY) && !dmem_ready &&
                         (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    // Wait counter. It is held at zero outside MEMORY, so every MEMORY
    // entry starts from zero, and it counts the cycles that dmem_ready stays low.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_q != S_MEMORY) begin
            wait_cnt <= '0;
        end else if (!dmem_ready) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Sticky fault flag. Only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (mem_timeout) begin
            fault_q <= 1'b1;
        end
    end

    assign fault = fault_q;
`else
    assign mem_timeout = 1'b0;
    assign fault       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------
    // Next-state and strobe decode from the current state and op_q.
    // The handshake and zero inputs qualify the decode only where the
    // instruction flow requires them.
    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path can leave one unassigned and infer a latch.
        state_d  = state_q;
        imem_req = 1'b0;
        ir_load  = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 1'b0;
        pc_en    = 1'b0;
        pc_src   = PC_INC;
        retire   = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = S_EXECUTE;
            end

            S_EXECUTE: begin
                case (kind)
                    K_ALU: begin
                        state_d = S_WRITEBACK;
                    end
                    K_LOAD, K_STORE: begin
                        state_d = S_MEMORY;
                    end
                    K_BEQ: begin
                        pc_en   = 1'b1;
                        pc_src  = zero ? PC_BRANCH : PC_INC;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    K_JAL: begin
                        // The link value (PC+1) uses the memory/link
                        // writeback path.
                        reg_we  = 1'b1;
                        wb_sel  = 1'b1;
                        pc_en   = 1'b1;
                        pc_src  = PC_JUMP;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    K_HALT: begin
                        retire  = 1'b1;
                        state_d = S_HALTED;
                    end
                    default: begin
                        pc_en   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = (kind == K_STORE);
                if (dmem_ready) begin
                    if (kind == K_STORE) begin
                        pc_en   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (mem_timeout) begin
                    // An abandoned access never retires and never moves the PC.
                    state_d = S_HALTED;
                end
            end

            S_WRITEBACK: begin
                reg_we  = 1'b1;
                wb_sel  = (kind == K_LOAD);
                pc_en   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end

            S_HALTED: begin
                state_d = S_HALTED;
            end

            default: begin
                // Unused encodings recover to FETCH.
                state_d = S_FETCH;
            end
        endcase
    end

    assign halted = (state_q == S_HALTED);
    assign state  = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer
//
// Directed, cycle-by-cycle bench for multicycle_sequencer. At each cycle it
// compares the state, a packed strobe vector and the retire counter against
// hand-computed values. A narrow counter (CNT_W=3) makes counter wrap-around
// reachable. TIMEOUT_CYCLES=4 applies when SEQ_MEM_TIMEOUT_EN is defined.

module tb_multicycle_sequencer;

    localparam int unsigned CNT_W = 3;

    // Strobe vector layout:
    // {imem_req, ir_load, dmem_req, dmem_we, reg_we, wb_sel, pc_en,
    //  pc_src[1:0], retire, halted, fault}
    localparam logic [11:0] NONE = 12'h000;
    localparam logic [11:0] IREQ = 12'h800;
    localparam logic [11:0] IRLD = 12'h400;
    localparam logic [11:0] DREQ = 12'h200;
    localparam logic [11:0] DWE  = 12'h100;
    localparam logic [11:0] RWE  = 12'h080;
    localparam logic [11:0] WBS  = 12'h040;
    localparam logic [11:0] PCEN = 12'h020;
    localparam logic [11:0] JMP  = 12'h010;  // pc_src = 10
    localparam logic [11:0] BR   = 12'h008;  // pc_src = 01
    localparam logic [11:0] RET  = 12'h004;
    localparam logic [11:0] HLT  = 12'h002;
    localparam logic [11:0] FLT  = 12'h001;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       opcode;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_load;
    logic             dmem_req;
    logic             dmem_we;
    logic             reg_we;
    logic             wb_sel;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             retire;
    logic [CNT_W-1:0] instr_count;
    logic             halted;
    logic             fault;
    logic [2:0]       state;
    logic [11:0]      strobes;

    int passed = 0;
    int total  = 0;

    multicycle_sequencer #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_load    (ir_load),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .retire     (retire),
        .instr_count(instr_count),
        .halted     (halted),
        .fault      (fault),
        .state      (state)
    );

    assign strobes = {imem_req, ir_load, dmem_req, dmem_we, reg_we, wb_sel,
                      pc_en, pc_src, retire, halted, fault};

    always #5 clk = ~clk;

    // Safety net in case the run ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] observed,
                         input logic [15:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Check one cycle's outputs, with the inputs already applied, then step
    // to just after the next rising edge.
    task automatic cyc(input string tag, input logic [2:0] exp_state,
                       input logic [11:0] exp_strobes,
                       input logic [CNT_W-1:0] exp_count);
        #1;
        check({tag, ".state"},   16'(state),       16'(exp_state));
        check({tag, ".strobes"}, 16'(strobes),     16'(exp_strobes));
        check({tag, ".count"},   16'(instr_count), 16'(exp_count));
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst        = 1'b1;
        opcode     = 4'b0000;
        zero       = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Reset state: FETCH, only imem_req, counter zero.
        cyc("reset", 3'd0, IREQ, 3'd0);

        // ADD with both ready signals high: 4 cycles, retire in cycle 3.
        imem_ready = 1'b1; dmem_ready = 1'b1; opcode = 4'b0000;
        cyc("add.f", 3'd0, IREQ | IRLD,       3'd0);
        cyc("add.d", 3'd1, NONE,              3'd0);
        cyc("add.e", 3'd2, NONE,              3'd0);
        cyc("add.w", 3'd4, RWE | PCEN | RET,  3'd0);

        // LOAD with dmem_ready low for 2 cycles: 7 cycles in total.
        opcode = 4'b0011; dmem_ready = 1'b0;
        cyc("ld.f",  3'd0, IREQ | IRLD, 3'd1);
        cyc("ld.d",  3'd1, NONE,        3'd1);
        cyc("ld.e",  3'd2, NONE,        3'd1);
        cyc("ld.m0", 3'd3, DREQ,        3'd1);
        cyc("ld.m1", 3'd3, DREQ,        3'd1);
        dmem_ready = 1'b1;
        cyc("ld.m2", 3'd3, DREQ,        3'd1);
        cyc("ld.w",  3'd4, RWE | WBS | PCEN | RET, 3'd1);

        // BEQ taken.
        opcode = 4'b0101; zero = 1'b1;
        cyc("beq1.f", 3'd0, IREQ | IRLD,     3'd2);
        cyc("beq1.d", 3'd1, NONE,            3'd2);
        cyc("beq1.e", 3'd2, PCEN | BR | RET, 3'd2);

        // BEQ not taken.
        zero = 1'b0;
        cyc("beq0.f", 3'd0, IREQ | IRLD, 3'd3);
        cyc("beq0.d", 3'd1, NONE,        3'd3);
        cyc("beq0.e", 3'd2, PCEN | RET,  3'd3);

        // JAL, preceded by one stalled fetch cycle.
        opcode = 4'b0111; imem_ready = 1'b0;
        cyc("jal.stall", 3'd0, IREQ, 3'd4);
        imem_ready = 1'b1;
        cyc("jal.f", 3'd0, IREQ | IRLD, 3'd4);
        cyc("jal.d", 3'd1, NONE,        3'd4);
        cyc("jal.e", 3'd2, RWE | WBS | PCEN | JMP | RET, 3'd4);

        // Unassigned opcode 1111 behaves as NOP.
        opcode = 4'b1111;
        cyc("op15.f", 3'd0, IREQ | IRLD, 3'd5);
        cyc("op15.d", 3'd1, NONE,        3'd5);
        cyc("op15.e", 3'd2, PCEN | RET,  3'd5);

        // NOP 1000.
        opcode = 4'b1000;
        cyc("nop.f", 3'd0, IREQ | IRLD, 3'd6);
        cyc("nop.d", 3'd1, NONE,        3'd6);
        cyc("nop.e", 3'd2, PCEN | RET,  3'd6);

        // ADDI retires the 8th instruction. The 3-bit counter wraps 7 -> 0.
        opcode = 4'b0010;
        cyc("addi.f", 3'd0, IREQ | IRLD,      3'd7);
        cyc("addi.d", 3'd1, NONE,             3'd7);
        cyc("addi.e", 3'd2, NONE,             3'd7);
        cyc("addi.w", 3'd4, RWE | PCEN | RET, 3'd7);

        // STORE with ready high: 4 cycles, retire in MEMORY.
        opcode = 4'b0100;
        cyc("st.f", 3'd0, IREQ | IRLD, 3'd0);
        cyc("st.d", 3'd1, NONE,        3'd0);
        cyc("st.e", 3'd2, NONE,        3'd0);
        cyc("st.m", 3'd3, DREQ | DWE | PCEN | RET, 3'd0);

        // STORE aborted by reset during the memory wait.
        cyc("sta.f", 3'd0, IREQ | IRLD, 3'd1);
        cyc("sta.d", 3'd1, NONE,        3'd1);
        dmem_ready = 1'b0;
        cyc("sta.e",  3'd2, NONE,       3'd1);
        cyc("sta.m0", 3'd3, DREQ | DWE, 3'd1);
        rst = 1'b1;
        cyc("sta.m1", 3'd3, DREQ | DWE, 3'd1);
        rst = 1'b0; imem_ready = 1'b0;
        cyc("sta.rst", 3'd0, IREQ, 3'd0);

        // HALT: retire in EXECUTE, then HALTED ignores both ready inputs.
        opcode = 4'b0110; imem_ready = 1'b1; dmem_ready = 1'b1;
        cyc("halt.f",  3'd0, IREQ | IRLD, 3'd0);
        cyc("halt.d",  3'd1, NONE,        3'd0);
        cyc("halt.e",  3'd2, RET,         3'd0);
        cyc("halt.h0", 3'd5, HLT,         3'd1);
        cyc("halt.h1", 3'd5, HLT,         3'd1);
        rst = 1'b1;
        cyc("halt.h2", 3'd5, HLT,         3'd1);
        rst = 1'b0; imem_ready = 1'b0;
        cyc("halt.rst", 3'd0, IREQ, 3'd0);

`ifdef SEQ_MEM_TIMEOUT_EN
        // LOAD that never gets dmem_ready: a fault after 4 waiting cycles.
        opcode = 4'b0011; imem_ready = 1'b1; dmem_ready = 1'b0;
        cyc("to.f",  3'd0, IREQ | IRLD, 3'd0);
        cyc("to.d",  3'd1, NONE,        3'd0);
        cyc("to.e",  3'd2, NONE,        3'd0);
        cyc("to.m0", 3'd3, DREQ,        3'd0);
        cyc("to.m1", 3'd3, DREQ,        3'd0);
        cyc("to.m2", 3'd3, DREQ,        3'd0);
        cyc("to.m3", 3'd3, DREQ,        3'd0);
        cyc("to.h0", 3'd5, HLT | FLT,   3'd0);
        rst = 1'b1;
        cyc("to.h1", 3'd5, HLT | FLT,   3'd0);
        rst = 1'b0; imem_ready = 1'b0;
        cyc("to.rst", 3'd0, IREQ, 3'd0);
`else
        // Without the watchdog, a long wait simply completes.
        opcode = 4'b0011; imem_ready = 1'b1; dmem_ready = 1'b0;
        cyc("lw.f", 3'd0, IREQ | IRLD, 3'd0);
        cyc("lw.d", 3'd1, NONE,        3'd0);
        cyc("lw.e", 3'd2, NONE,        3'd0);
        for (int i = 0; i < 6; i++) begin
            cyc("lw.wait", 3'd3, DREQ, 3'd0);
        end
        dmem_ready = 1'b1;
        cyc("lw.m", 3'd3, DREQ, 3'd0);
        cyc("lw.w", 3'd4, RWE | WBS | PCEN | RET, 3'd0);
        imem_ready = 1'b0;
        cyc("lw.next", 3'd0, IREQ, 3'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
